// File: rtl/mips_muldiv_unit_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide sequencer.
package mips_muldiv_unit_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

  // Magnitude of an operand; 0x80000000 maps to itself, which is its true magnitude.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// 64-bit accumulator/remainder datapath with one radix-2 multiply or divide step per cycle.
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] acc
);

  logic [31:0] operand_q;
  logic [63:0] acc_q;
  logic [63:0] acc_next;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;

  // MUL: acc = {partial product, multiplier}; DIV: acc = {remainder, dividend -> quotient}.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_next  = acc_q;
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? operand_q : 32'd0)};
    rem_shift = acc_q[63:31];
    rem_diff  = rem_shift - {1'b0, operand_q};
    if (step) begin
      if (is_div) begin
        acc_next = rem_diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                                : {rem_diff[31:0],  acc_q[30:0], 1'b1};
      end else begin
        acc_next = {mul_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand_q <= '0;
      acc_q     <= '0;
    end else if (load) begin
      operand_q <= is_div ? b_mag : a_mag;
      acc_q     <= {32'd0, (is_div ? a_mag : b_mag)};
    end else begin
      acc_q     <= acc_next;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with PC stall arbitration.
module mips_muldiv_unit
  import mips_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e   state_q;
  md_op_e      op_q;
  md_op_e      op_in;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        neg_q;
  logic        rem_neg_q;
  logic        div_zero_q;
  logic [31:0] dividend_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        load;
  logic        step;
  logic        is_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign op_in  = md_op_e'(op);
  assign load   = (state_q == MD_IDLE) && start;
  assign step   = (state_q == MD_RUN);
  assign is_div = load ? md_is_div(op_in) : md_is_div(op_q);
  assign a_mag  = md_abs(rs_val, md_is_signed(op_in));
  assign b_mag  = md_abs(rt_val, md_is_signed(op_in));

  muldiv_iter u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc)
  );

  // Sign fix-up; divide-by-zero bypasses the loop result entirely.
  assign prod = neg_q ? -acc : acc;
  assign quo  = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
  assign rem  = div_zero_q ? dividend_q : (rem_neg_q ? -acc[63:32] : acc[63:32]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_OP_MULT;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q    <= MD_RUN;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            op_q       <= op_in;
            neg_q      <= md_is_signed(op_in) & (rs_val[31] ^ rt_val[31]);
            rem_neg_q  <= md_is_signed(op_in) & rs_val[31];
            div_zero_q <= (rt_val == 32'd0);
            dividend_q <= rs_val;
          end else begin
            if (mthi) hi_q <= rs_val;
            if (mtlo) lo_q <= rs_val;
          end
        end
        MD_RUN: begin
          if (cnt_q == 5'(MD_ITERS - 1)) state_q <= MD_FIX;
          else                           cnt_q   <= cnt_q + 5'd1;
        end
        MD_FIX: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= '0;
          if (md_is_div(op_q)) begin
            hi_q <= rem;
            lo_q <= quo;
          end else begin
            {hi_q, lo_q} <= prod;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (start | rd_req | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomized self-checking bench for mips_muldiv_unit against an arithmetic reference model.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        rd_req = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .rd_req (rd_req),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MIPS HI/LO result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    int              q;
    int              r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issues one op at the current negedge and follows it to its done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
    logic [63:0] r;
    int          cyc;
    int          busy_cycles;
    bit          seen;
    r = ref_md(o, a, b);
    check("idle_before_start", busy, 1'b0);
    op = o; rs_val = a; rt_val = b; start = 1'b1; mthi = disturb;
    #1 check("stall_idle_start", stall, 1'b0);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    cyc = 1; busy_cycles = 0; seen = 1'b0;
    check("done_pulse_width", done, 1'b0);
    check("hi_after_start", hi, exp_hi);
    check("lo_after_start", lo, exp_lo);
    while (!seen && cyc < 100) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (disturb && cyc == 5) begin
          start = 1'b1; op = ~o; rs_val = $urandom; rt_val = $urandom;
          rd_req = 1'b1; mthi = 1'b1; mtlo = 1'b1;
          #1 check("stall_busy", stall, 1'b1);
        end
        if (disturb && cyc == 20) begin
          rd_req = 1'b1;
          #1 check("stall_mflo_busy", stall, 1'b1);
          check("hold_hi", hi, exp_hi);
          check("hold_lo", lo, exp_lo);
        end
        @(negedge clk);
        start = 1'b0; rd_req = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        cyc++;
      end
    end
    check("done_seen", seen, 1'b1);
    check("done_latency", cyc, 34);
    check("busy_cycles", busy_cycles, 33);
    check("busy_in_done", busy, 1'b0);
    check("result_hi", hi, r[63:32]);
    check("result_lo", lo, r[31:0]);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    if (disturb) begin
      rd_req = 1'b1;
      #1 check("stall_done_cycle", stall, 1'b0);
      rd_req = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rd_req = 1'b1;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rd_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    @(negedge clk);
    check("ignored_start_idle", busy, 1'b0);
    run_op(2'b11, 32'd7, 32'd0, 1'b0);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi, 32'h0000_0007);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    @(negedge clk);
    rs_val = 32'h1234_5678; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_idle", lo, 32'h1234_5678);
    rs_val = 32'hCAFE_F00D; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle", hi, 32'hCAFE_F00D);
    exp_hi = hi;
    exp_lo = lo;

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    run_op(2'b01, $urandom, $urandom, 1'b0);
    op = 2'b01; rs_val = $urandom; rt_val = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_stall", stall, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    rd_req = 1'b0;
    rst = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    run_op(2'b01, 32'd2, 32'd3, 1'b0);
    check("post_rst_lo", lo, 32'd6);
    check("post_rst_hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
